// File: rtl/tawas_rcn_slave.sv
// rtl/tawas_rcn_slave.sv - RCN ring target node bridging window hits to a local ack bus
module tawas_rcn_slave #(
  parameter logic [20:0] ADDR_BASE = 21'h000000,
  parameter logic [20:0] ADDR_MASK = 21'h1FF000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [66:0] rcn_in,
  output logic [66:0] rcn_out,
  output logic        cs,
  output logic        wr,
  output logic [23:0] addr,
  output logic [3:0]  mask,
  output logic [31:0] wdata,
  input  logic        ack,
  input  logic [31:0] rdata
);

  typedef enum logic [1:0] {IDLE, BUS, RSP} state_t;

  state_t      state;
  // Request minus vld/req; data field is replaced by rdata on a read ack.
  logic [64:0] held;
  logic        hit;

  assign hit = rcn_in[66] & rcn_in[65] &
               ((rcn_in[52:32] & ADDR_MASK) == ADDR_BASE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      held    <= '0;
      rcn_out <= '0;
      cs      <= 1'b0;
      wr      <= 1'b0;
      addr    <= '0;
      mask    <= '0;
      wdata   <= '0;
    end else begin
      rcn_out <= rcn_in;
      case (state)
        IDLE: begin
          if (hit) begin
            held    <= rcn_in[64:0];
            rcn_out <= '0;
            cs      <= 1'b1;
            wr      <= rcn_in[64];
            addr    <= {1'b0, rcn_in[52:32], 2'b00};
            mask    <= rcn_in[59:56];
            wdata   <= rcn_in[31:0];
            state   <= BUS;
          end
        end
        BUS: begin
          if (ack) begin
            cs <= 1'b0;
            if (!held[64]) held[31:0] <= rdata;
            state <= RSP;
          end
        end
        RSP: begin
          // Occupied slots keep circulating; the response waits for a hole.
          if (!rcn_in[66]) begin
            rcn_out <= {2'b10, held};
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tawas_rcn_slave.sv
// tb/tb_tawas_rcn_slave.sv - self-checking bench for tawas_rcn_slave
module tb_tawas_rcn_slave;

  logic        clk;
  logic        rst;
  logic [66:0] rcn_in;
  logic [66:0] rcn_out;
  logic        cs;
  logic        wr;
  logic [23:0] addr;
  logic [3:0]  mask;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  int n_checks = 0;
  int n_fail   = 0;

  tawas_rcn_slave dut (
    .clk(clk), .rst(rst), .rcn_in(rcn_in), .rcn_out(rcn_out),
    .cs(cs), .wr(wr), .addr(addr), .mask(mask), .wdata(wdata),
    .ack(ack), .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [66:0] din;
    logic        ack;
    logic [31:0] rdata;
    logic [66:0] dout;
    logic        cs;
    logic [23:0] addr;
  } vec_t;

  function automatic logic [66:0] mk(input logic v, input logic r, input logic w,
                                     input logic [3:0] src, input logic [3:0] m,
                                     input logic [2:0] seq, input logic [20:0] a,
                                     input logic [31:0] d);
    return {v, r, w, src, m, seq, a, d};
  endfunction

  task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Random ring traffic: empty slots, invalid junk, and requests/responses in and out of the window.
  function automatic logic [66:0] rand_pkt();
    logic [66:0] p;
    int          k;
    k = $urandom_range(0, 9);
    p = {$urandom, $urandom, $urandom};
    if (k < 4) return '0;
    if (k == 4) p[66] = 1'b0;
    else p[66] = 1'b1;
    if ($urandom_range(0, 1) == 1) p[52:44] = '0;
    else if (p[52:44] == '0) p[52] = 1'b1;
    return p;
  endfunction

  vec_t        vecs[9];
  logic [66:0] pk, w, r2, fr[3], r3, r4, r6, exp_out;
  logic        held_m, done_m, exp_cs, in_hit;
  logic [66:0] hreq;

  initial begin
    rst = 1'b0; rcn_in = '0; ack = 1'b0; rdata = '0;
    #1;
    chk("reset_out", rcn_out, '0);
    chk("reset_local", 67'({cs, wr, addr, mask, wdata}), '0);
    step();
    step();
    rst = 1'b1;
    step();

    // Table: pass-through, responses/invalid slots in window, minimum-latency read hit.
    pk = mk(1, 1, 0, 4'h0, 4'hF, 3'd0, 21'h001000, 32'h1234);
    vecs[0] = '{pk, 1'b0, 32'h0, pk, 1'b0, 24'h0};
    vecs[1] = '{67'h0, 1'b0, 32'h0, 67'h0, 1'b0, 24'h0};
    pk = mk(1, 0, 1, 4'h2, 4'hF, 3'd1, 21'h000010, 32'h5555);
    vecs[2] = '{pk, 1'b0, 32'h0, pk, 1'b0, 24'h0};
    pk = mk(0, 1, 0, 4'h2, 4'hF, 3'd1, 21'h000010, 32'h7777);
    vecs[3] = '{pk, 1'b1, 32'h0, pk, 1'b0, 24'h0};
    pk = mk(1, 1, 0, 4'h3, 4'hF, 3'd5, 21'h000010, 32'h0);
    vecs[4] = '{pk, 1'b0, 32'h0, 67'h0, 1'b1, 24'h000040};
    vecs[5] = '{67'h0, 1'b1, 32'hDEADBEEF, 67'h0, 1'b0, 24'h0};
    vecs[6] = '{67'h0, 1'b0, 32'h0,
                mk(1, 0, 0, 4'h3, 4'hF, 3'd5, 21'h000010, 32'hDEADBEEF), 1'b0, 24'h0};
    vecs[7] = '{67'h0, 1'b0, 32'h0, 67'h0, 1'b0, 24'h0};
    vecs[8] = '{67'h0, 1'b0, 32'h0, 67'h0, 1'b0, 24'h0};
    for (int i = 0; i < 9; i++) begin
      rcn_in = vecs[i].din; ack = vecs[i].ack; rdata = vecs[i].rdata;
      step();
      chk($sformatf("vec%0d_out", i), rcn_out, vecs[i].dout);
      chk($sformatf("vec%0d_cs", i), 67'(cs), 67'(vecs[i].cs));
      if (vecs[i].cs) chk($sformatf("vec%0d_addr", i), 67'(addr), 67'(vecs[i].addr));
    end
    ack = 1'b0;

    // Write hit, ack in the fifth cs cycle.
    w = mk(1, 1, 1, 4'h7, 4'h3, 3'd2, 21'h000ABC, 32'hA5A5A5A5);
    rcn_in = w;
    step();
    rcn_in = '0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("wr_cs%0d", i), 67'(cs), 67'(1'b1));
      chk($sformatf("wr_bus%0d", i), 67'({wr, addr, mask, wdata}),
          67'({1'b1, 24'h002AF0, 4'h3, 32'hA5A5A5A5}));
      ack = (i == 4);
      rdata = 32'h11111111;
      step();
    end
    ack = 1'b0;
    chk("wr_cs_drop", 67'(cs), 67'(1'b0));
    step();
    chk("wr_rsp", rcn_out, mk(1, 0, 1, 4'h7, 4'h3, 3'd2, 21'h000ABC, 32'hA5A5A5A5));
    step();

    // Slot contention during RSP.
    r2 = mk(1, 1, 0, 4'h9, 4'hC, 3'd3, 21'h000123, 32'h0);
    rcn_in = r2;
    step();
    rcn_in = '0; ack = 1'b1; rdata = 32'hCAFEF00D;
    step();
    ack = 1'b0;
    fr[0] = mk(1, 1, 0, 4'h1, 4'h1, 3'd1, 21'h005000, 32'h1);
    fr[1] = mk(1, 0, 1, 4'h2, 4'h2, 3'd2, 21'h000010, 32'h2);
    fr[2] = mk(1, 1, 1, 4'h3, 4'h3, 3'd3, 21'h000020, 32'h3);
    for (int i = 0; i < 3; i++) begin
      rcn_in = fr[i];
      step();
      chk($sformatf("cont_fwd%0d", i), rcn_out, fr[i]);
      chk($sformatf("cont_cs%0d", i), 67'(cs), 67'(1'b0));
    end
    rcn_in = '0;
    step();
    chk("cont_rsp", rcn_out, mk(1, 0, 0, 4'h9, 4'hC, 3'd3, 21'h000123, 32'hCAFEF00D));
    step();
    chk("cont_after", rcn_out, '0);

    // Busy collision: second hit during BUS is forwarded.
    r3 = mk(1, 1, 0, 4'h4, 4'hF, 3'd4, 21'h000044, 32'h0);
    r4 = mk(1, 1, 1, 4'h5, 4'h1, 3'd6, 21'h000055, 32'h55AA55AA);
    rcn_in = r3;
    step();
    rcn_in = r4;
    step();
    chk("busy_fwd", rcn_out, r4);
    chk("busy_addr", 67'({cs, wr, addr}), 67'({1'b1, 1'b0, 24'h000110}));
    rcn_in = '0; ack = 1'b1; rdata = 32'h0BADC0DE;
    step();
    ack = 1'b0;
    step();
    chk("busy_rsp", rcn_out, mk(1, 0, 0, 4'h4, 4'hF, 3'd4, 21'h000044, 32'h0BADC0DE));
    chk("busy_one_cs", 67'(cs), 67'(1'b0));
    rcn_in = r4;
    step();
    chk("recapture_out", rcn_out, '0);
    chk("recapture_cs", 67'({cs, wr, wdata}), 67'({1'b1, 1'b1, 32'h55AA55AA}));
    rcn_in = '0; ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    chk("recapture_rsp", rcn_out, mk(1, 0, 1, 4'h5, 4'h1, 3'd6, 21'h000055, 32'h55AA55AA));

    // Asynchronous reset in BUS; stale ack ignored, nothing emitted afterwards.
    rcn_in = mk(1, 1, 0, 4'h6, 4'hF, 3'd7, 21'h000066, 32'h0);
    step();
    rcn_in = mk(1, 0, 0, 4'h8, 4'h8, 3'd0, 21'h007000, 32'h8);
    chk("rst_pre_cs", 67'(cs), 67'(1'b1));
    #2 rst = 1'b0;
    #1;
    chk("rst_async_cs", 67'(cs), 67'(1'b0));
    chk("rst_async_out", rcn_out, '0);
    rcn_in = '0; ack = 1'b1; rdata = 32'hFFFFFFFF;
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rst_quiet%0d", i), rcn_out, '0);
      chk($sformatf("rst_nocs%0d", i), 67'(cs), 67'(1'b0));
    end
    ack = 1'b0;
    r6 = mk(1, 1, 0, 4'hA, 4'h6, 3'd1, 21'h000FFF, 32'h0);
    rcn_in = r6;
    step();
    rcn_in = '0; ack = 1'b1; rdata = 32'h600DF00D;
    chk("rst_next_cs", 67'({cs, addr}), 67'({1'b1, 24'h003FFC}));
    step();
    ack = 1'b0;
    step();
    chk("rst_next_rsp", rcn_out, mk(1, 0, 0, 4'hA, 4'h6, 3'd1, 21'h000FFF, 32'h600DF00D));

    // Random traffic against a transaction-level reference.
    held_m = 1'b0; done_m = 1'b0; hreq = '0;
    for (int c = 0; c < 2000; c++) begin
      rcn_in = rand_pkt();
      ack    = ($urandom_range(0, 2) == 0);
      rdata  = $urandom;
      in_hit = rcn_in[66] && rcn_in[65] && (rcn_in[52:44] == 9'h0);
      exp_out = rcn_in;
      if (!held_m) begin
        if (in_hit) begin
          exp_out = '0; held_m = 1'b1; done_m = 1'b0; hreq = rcn_in;
        end
      end else if (!done_m) begin
        if (ack) begin
          done_m = 1'b1;
          if (!hreq[64]) hreq[31:0] = rdata;
        end
      end else if (!rcn_in[66]) begin
        exp_out = {2'b10, hreq[64:0]};
        held_m = 1'b0;
      end
      exp_cs = held_m && !done_m;
      step();
      chk("rnd_out", rcn_out, exp_out);
      chk("rnd_cs", 67'(cs), 67'(exp_cs));
      if (exp_cs)
        chk("rnd_bus", 67'({wr, addr, mask, wdata}),
            67'({hreq[64], 1'b0, hreq[52:32], 2'b00, hreq[59:56], hreq[31:0]}));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tawas_rcn_slave.md
Name: tawas_rcn_slave

Overview:
- Ring-bus (RCN) target node that sits on the 67-bit ring driven by the tawas core's rcn_out port and feeds the core's rcn_in port.
- Requests addressed to this node's window are removed from the ring and executed on a simple local register/SRAM bus with an ack handshake.
- The result is reinserted as a response packet in the next free ring slot.
- All other packets are forwarded with one register stage.

Parameters:
- ADDR_BASE, 21'h000000, word-address base of the window (matches packet addr field bits [52:32]).
- ADDR_MASK, 21'h1FF000, mask applied to the packet address before comparison with ADDR_BASE.

Ports:
- clk  input  1  core clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- rcn_in  input  67  ring slot from the upstream node.
- rcn_out  output  67  ring slot to the downstream node (registered).
- cs  output  1  local bus request, held until ack.
- wr  output  1  local bus write (1) or read (0).
- addr  output  24  local byte address, {1'b0, pkt_addr, 2'b00}.
- mask  output  4  byte enables.
- wdata  output  32  write data.
- ack  input  1  local bus completion; sampled only while cs=1.
- rdata  input  32  read data, valid in the cycle ack=1.

Behaviour:
- Packet fields (fixed format):
  - [66] vld
  - [65] req (1 = request, 0 = response)
  - [64] wr
  - [63:60] src_id
  - [59:56] mask
  - [55:53] seq (write-back register tag)
  - [52:32] addr (word address)
  - [31:0] data
- Hit: vld & req & ((addr & ADDR_MASK) == ADDR_BASE).
- Reset (rst low, asynchronous): rcn_out=0, cs=0, wr=0, addr=0, mask=0, wdata=0, state=IDLE, held packet cleared. A transaction in flight is dropped with no response; ack arriving during or after reset is ignored.
- Default forward path: rcn_out <= rcn_in every cycle unless a capture or an insertion applies. This gives 1-cycle latency per node.
- IDLE:
  - On a hit, capture the whole packet and write rcn_out <= 67'h0 (slot emptied). Next state is BUS.
  - In the same edge, cs<=1 and wr/addr/mask/wdata are loaded from the packet.
- BUS:
  - cs and all local outputs stay constant until ack=1 is sampled.
  - On ack, cs<=0. The held data field becomes rdata for reads; it keeps the original wdata for writes. Next state is RSP.
  - There is no timeout; a stuck ack stalls this node only.
- RSP:
  - If rcn_in[66]==0, rcn_out <= response and next state is IDLE.
  - Otherwise the incoming packet is forwarded and the node stays in RSP; it retries every cycle.
  - Response packet: vld=1, req=0. wr, src_id, mask, seq and addr are copied from the request; data is as captured in BUS.
- BUS or RSP with an incoming hit: the packet is forwarded unchanged (not captured) and circulates the ring for a later attempt. Only one transaction is outstanding at a time.
- Response packets (req=0) and non-hit requests are never captured, regardless of address.
- Minimum end-to-end latency for a hit at rcn_in in cycle N, with ack in cycle N+1 and a free slot in cycle N+2:
  - cs high during N+1.
  - Response visible on rcn_out in cycle N+3.
- When a hit request arrives in the same cycle the node leaves RSP, the node is still in RSP for that cycle, so the slot is non-empty and is forwarded. Capture is possible again from the next cycle.

Test Plan:
1. Pass-through (ADDR_BASE=0, ADDR_MASK=21'h1FF000): drive a request with addr=21'h001000, data=32'h1234 -> identical packet on rcn_out 1 cycle later; cs stays 0.
2. Read hit: request vld=1, req=1, wr=0, src=3, seq=5, addr=21'h000010, mask=4'hF; ack in the first cs cycle with rdata=32'hDEADBEEF; idle ring ->
   - rcn_out is 0 the cycle after the request.
   - addr=24'h000040 while cs is high.
   - Response {vld=1, req=0, src=3, seq=5, data=32'hDEADBEEF} appears 3 cycles after the request.
3. Write hit, ack delayed 4 cycles: wdata=32'hA5A5A5A5, mask=4'h3 -> cs high for exactly 5 cycles with wr, addr, mask and wdata stable; response echoes data 32'hA5A5A5A5 with wr=1.
4. Slot contention: during RSP, hold rcn_in vld=1 with foreign packets for 3 cycles -> those 3 are forwarded intact; the response is inserted in the first empty slot.
5. Busy collision: a second hit arrives while in BUS -> the second packet is forwarded unchanged; only one cs transaction occurs.
6. Reset mid-operation: assert rst low while in BUS -> cs=0 and rcn_out=0 immediately (asynchronous); no response is ever emitted after release; the next hit is served normally.
